// File: rtl/leaf_xbar_scheduler.sv
// leaf_xbar_scheduler: grant scheduler for a 5-port leaf crossbar.
// Requester 0 is the local GPU, requesters 1-4 are spine links. One flow is
// granted at a time (round-robin), routed up/down/drop by its destination
// group, and held until its burst completes, its request drops, or it is a
// drop route.
// Optional feature: define LEAF_XBAR_STARVE_GUARD_EN to add a per-requester
// wait counter that forces a long-waiting requester to win arbitration.
module leaf_xbar_scheduler #(
  parameter logic [3:0] GROUP_ID  = 4'b0100,
  parameter int         BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arb_enable,
  input  logic [4:0]  req,
  input  logic [29:0] dest_addr_flat,
  input  logic        beat_done,
  output logic [4:0]  gnt,
  output logic [2:0]  current_grant,
  output logic [1:0]  direction,
  output logic        busy,
  output logic [3:0]  beat_cnt
);

  localparam int NREQ = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_gnt;
  logic [2:0]  r_cg;
  logic [1:0]  r_dir;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [2:0]  r_ptr;   // last winner; search starts at r_ptr+1
  logic [2:0]  r_win;   // winner of the active grant, kept for the pointer update

  logic [3:0]  w_sum;
  logic        w_rr_found;
  logic [2:0]  w_rr_win;
  logic        w_starve;
  logic [2:0]  w_starve_win;
  logic [2:0]  w_win;
  logic        w_take;
  logic [3:0]  w_grp;
  logic [1:0]  w_dir;
  logic [3:0]  w_cnt_nxt;
  logic        w_release;
  logic        w_unused_lsb;

  // Only the group field [5:2] of each destination takes part in routing.
  assign w_unused_lsb = ^{dest_addr_flat[25:24], dest_addr_flat[19:18],
                          dest_addr_flat[13:12], dest_addr_flat[7:6],
                          dest_addr_flat[1:0]};

  // Round-robin search: first requester found walking from r_ptr+1 modulo 5.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = 3'd0;
    w_sum      = 4'd0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + 4'(k);
      if (w_sum >= 4'd5) w_sum = w_sum - 4'd5;
      if (!w_rr_found && req[w_sum[2:0]]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_sum[2:0];
      end
    end
  end

`ifdef LEAF_XBAR_STARVE_GUARD_EN
  logic [NREQ-1:0][5:0] r_wait;

  // Starving requester (waited 32+ cycles) overrides the pointer; lowest index wins.
  always_comb begin
    w_starve     = 1'b0;
    w_starve_win = 3'd0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i] && r_wait[i][5]) begin
        w_starve     = 1'b1;
        w_starve_win = 3'(i);
      end
    end
  end

  // Wait counters: count cycles requesting without holding the grant, clear on win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (r_state == S_IDLE && w_take && w_win == 3'(i))
          r_wait[i] <= 6'd0;
        else if (req[i] && !r_gnt[i] && r_wait[i] != 6'h3F)
          r_wait[i] <= r_wait[i] + 6'd1;
      end
    end
  end
`else
  assign w_starve     = 1'b0;
  assign w_starve_win = 3'd0;
`endif

  assign w_win  = w_starve ? w_starve_win : w_rr_win;
  assign w_take = arb_enable && w_rr_found;

  // Destination group of the candidate winner.
  always_comb begin
    w_grp = dest_addr_flat[5:2];
    case (w_win)
      3'd1:    w_grp = dest_addr_flat[11:8];
      3'd2:    w_grp = dest_addr_flat[17:14];
      3'd3:    w_grp = dest_addr_flat[23:20];
      3'd4:    w_grp = dest_addr_flat[29:26];
      default: w_grp = dest_addr_flat[5:2];
    endcase
  end

  // Route: GPU goes up unless local (drop); spines go down if local, else drop.
  always_comb begin
    if (w_win == 3'd0) w_dir = (w_grp == GROUP_ID) ? 2'b11 : 2'b01;
    else               w_dir = (w_grp == GROUP_ID) ? 2'b10 : 2'b11;
  end

  // Release is evaluated against the count including this cycle's beat.
  assign w_cnt_nxt = r_cnt + {3'd0, beat_done};
  assign w_release = (w_cnt_nxt >= 4'(BURST_LEN)) || !req[r_win] || (r_dir == 2'b11);

  // Scheduler FSM with registered grant outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= 5'd0;
      r_cg    <= 3'b111;
      r_dir   <= 2'b00;
      r_busy  <= 1'b0;
      r_cnt   <= 4'd0;
      r_ptr   <= 3'd4;
      r_win   <= 3'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_GRANT;
            r_gnt   <= 5'd1 << w_win;
            r_cg    <= w_win;
            r_dir   <= w_dir;
            r_busy  <= 1'b1;
            r_cnt   <= 4'd0;
            r_win   <= w_win;
          end
        end
        S_GRANT: begin
          r_state <= S_HOLD;
          if (beat_done) r_cnt <= w_cnt_nxt;
        end
        S_HOLD: begin
          if (w_release) begin
            r_state <= S_RELEASE;
            r_gnt   <= 5'd0;
            r_cg    <= 3'b111;
            r_dir   <= 2'b00;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
          end else if (beat_done) begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RELEASE: begin
          r_ptr   <= r_win;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign current_grant = r_cg;
  assign direction     = r_dir;
  assign busy          = r_busy;
  assign beat_cnt      = r_cnt;

endmodule
